// File: rtl/axi_line_fill_master_pkg.sv
// Shared definitions for the AXI line-fill master: burst encodings, FSM states and line geometry.
package axi_fill_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RSP  = 2'd3
    } fill_state_e;

    localparam int DEF_LINE_BYTES = 64;
    localparam int DEF_DATA_WIDTH = 64;

    function automatic int beats_of(input int line_bytes, input int data_width);
        return (line_bytes * 8) / data_width;
    endfunction

    localparam int DEF_BEATS    = beats_of(DEF_LINE_BYTES, DEF_DATA_WIDTH);
    localparam int DEF_AXI_SIZE = $clog2(DEF_DATA_WIDTH / 8);

endpackage

// File: rtl/axi_line_fill_master_if.sv
// AXI read-address and read-data channels between the fill master and the memory responder.
interface axi_line_fill_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) ();
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [ID_WIDTH-1:0]   arid;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_line_fill_master_line_buf.sv
// Line buffer: one register per beat, flattened so beat k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
module fill_line_buf #(
    parameter int BEATS      = 8,
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        clr_i,
    output logic [BEATS*DATA_WIDTH-1:0] line_o
);
    logic [BEATS-1:0][DATA_WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (clr_i) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[idx_i] <= data_i;
        end
    end

    assign line_o = mem_q;
endmodule

// File: rtl/axi_line_fill_master.sv
// Cache line-fill AXI read master: one AR burst per request, beats collected into a line buffer.
// CWF_WRAP_EN selects critical-word-first WRAP bursts; undefined gives line-aligned INCR bursts.
//   state  | meaning
//   S_IDLE | ready for a fill request
//   S_AR   | presenting the AR burst, waiting for arready
//   S_R    | collecting R beats until rlast
//   S_RSP  | full line presented until rsp_ready
module axi_line_fill_master
    import axi_fill_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                  ID_WIDTH   = 4,
    parameter int                  LINE_BYTES = DEF_LINE_BYTES,
    parameter logic [ID_WIDTH-1:0] FILL_ID    = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    axi_line_fill_master_if.master  axi,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [LINE_BYTES*8-1:0] rsp_data,
    output logic                    rsp_err
);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEATS      = beats_of(LINE_BYTES, DATA_WIDTH);
    localparam int IDX_W      = $clog2(BEATS);
    localparam int SIZE       = $clog2(BEAT_BYTES);

`ifdef CWF_WRAP_EN
    localparam int                    LINE_SHIFT = $clog2(LINE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = ~ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [1:0]            BURST_KIND = BURST_WRAP;
`else
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = ~ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [1:0]            BURST_KIND = BURST_INCR;
`endif

    fill_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [1:0]            arburst_q, arburst_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;
    logic                  buf_we, buf_clr;
    logic [IDX_W-1:0]      buf_idx;

`ifdef CWF_WRAP_EN
    logic [IDX_W-1:0] start_q, start_d;
    assign buf_idx = start_q + cnt_q;
`else
    assign buf_idx = cnt_q;
`endif

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arburst_d = arburst_q;
        cnt_d     = cnt_q;
        full_d    = full_q;
        err_d     = err_q;
        buf_we    = 1'b0;
        buf_clr   = 1'b0;
`ifdef CWF_WRAP_EN
        start_d   = start_q;
`endif
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d   = S_AR;
                araddr_d  = req_addr & ADDR_MASK;
                arburst_d = BURST_KIND;
                buf_clr   = 1'b1;
`ifdef CWF_WRAP_EN
                start_d   = req_addr[LINE_SHIFT-1:SIZE];
`endif
            end
            S_AR: if (axi.arready) state_d = S_R;
            S_R: if (axi.rvalid) begin
                if (axi.rresp != 2'b00 || axi.rid != FILL_ID) err_d = 1'b1;
                // full_q marks that all slots are written; later beats are dropped as overruns
                if (full_q) begin
                    err_d = 1'b1;
                end else begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(BEATS - 1)) full_d = 1'b1;
                end
                if (axi.rlast) begin
                    if (cnt_q != IDX_W'(BEATS - 1)) err_d = 1'b1;
                    state_d = S_RSP;
                end
            end
            S_RSP: if (rsp_ready) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                full_d  = 1'b0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            araddr_q  <= '0;
            arburst_q <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CWF_WRAP_EN
            start_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arburst_q <= arburst_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            err_q     <= err_d;
`ifdef CWF_WRAP_EN
            start_q   <= start_d;
`endif
        end
    end

    fill_line_buf #(
        .BEATS     (BEATS),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W)
    ) u_line_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (buf_we),
        .idx_i (buf_idx),
        .data_i(axi.rdata),
        .clr_i (buf_clr),
        .line_o(rsp_data)
    );

    // rst_n gating keeps req_ready low while reset is held, even though S_IDLE is the reset state
    assign req_ready   = (state_q == S_IDLE) && rst_n;
    assign axi.arvalid = (state_q == S_AR);
    assign axi.araddr  = araddr_q;
    assign axi.arid    = FILL_ID;
    assign axi.arlen   = 4'(BEATS - 1);
    assign axi.arsize  = 3'(SIZE);
    assign axi.arburst = arburst_q;
    assign axi.rready  = (state_q == S_R);
    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_err     = (state_q == S_RSP) && err_q;
endmodule

// File: tb/tb_axi_line_fill_master.sv
// Bench for axi_line_fill_master: randomized fills checked against a line/err reference model.
module tb_axi_line_fill_master;
    import axi_fill_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [511:0] rsp_data;
    logic         rsp_err;

    axi_line_fill_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) axi ();

    axi_line_fill_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .LINE_BYTES(64), .FILL_ID(4'd0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .axi      (axi),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] beat_d    [16];
    logic [1:0]  beat_resp [16];
    logic [3:0]  beat_id   [16];

    int           obs_timeout, obs_ar_lat, obs_rsp_lat;
    logic         obs_req_ready, obs_ar_stable, obs_rready_ok, obs_early_rsp, obs_hold_ok, obs_idle;
    logic [31:0]  obs_araddr;
    logic [1:0]   obs_arburst;
    logic [3:0]   obs_arlen, obs_arid;
    logic [2:0]   obs_arsize;
    logic [511:0] obs_line;
    logic         obs_err;

    // Reference model: where each beat lands in the line and what the burst must look like
    function automatic int slot_of(input logic [31:0] addr, input int k);
`ifdef CWF_WRAP_EN
        return (int'(addr[5:3]) + k) % 8;
`else
        return k;
`endif
    endfunction

    function automatic logic [31:0] model_araddr(input logic [31:0] addr);
`ifdef CWF_WRAP_EN
        return addr - (addr % 8);
`else
        return addr - (addr % 64);
`endif
    endfunction

    function automatic logic [1:0] model_arburst();
`ifdef CWF_WRAP_EN
        return 2'd2;
`else
        return 2'd1;
`endif
    endfunction

    function automatic logic [511:0] model_line(input logic [31:0] addr, input int n);
        logic [511:0] l = '0;
        for (int k = 0; k < n && k < 8; k++) l[slot_of(addr, k)*64 +: 64] = beat_d[k];
        return l;
    endfunction

    function automatic logic [511:0] model_mask(input logic [31:0] addr, input int n);
        logic [511:0] m = '0;
        for (int k = 0; k < n && k < 8; k++) m[slot_of(addr, k)*64 +: 64] = '1;
        return m;
    endfunction

    function automatic logic model_err(input int n);
        for (int k = 0; k < n; k++) if (beat_resp[k] != 2'd0 || beat_id[k] != 4'd0) return 1'b1;
        return (n != 8);
    endfunction

    task automatic gen_beats();
        for (int k = 0; k < 16; k++) begin
            beat_d[k]    = {$urandom, $urandom};
            beat_resp[k] = 2'd0;
            beat_id[k]   = 4'd0;
        end
    endtask

    // Stimulus only: runs one fill and records what the DUT showed; tests judge the results
    task automatic do_fill(input logic [31:0] addr, input int n, input int ar_wait, input int rsp_wait);
        obs_timeout = 0;
        @(negedge clk);
        req_addr = addr;
        req_valid = 1'b1;
        obs_req_ready = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        obs_ar_lat = 1;
        while (!axi.arvalid && obs_ar_lat < 20) begin
            @(negedge clk);
            obs_ar_lat++;
        end
        if (!axi.arvalid) obs_timeout++;
        obs_araddr = axi.araddr; obs_arburst = axi.arburst; obs_arlen = axi.arlen;
        obs_arsize = axi.arsize; obs_arid = axi.arid;
        obs_ar_stable = 1'b1;
        repeat (ar_wait) begin
            @(negedge clk);
            if (axi.arvalid !== 1'b1 || axi.araddr !== obs_araddr || axi.arburst !== obs_arburst)
                obs_ar_stable = 1'b0;
        end
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        obs_rready_ok = 1'b1;
        obs_early_rsp = 1'b0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            if (axi.rready !== 1'b1) obs_rready_ok = 1'b0;
            if (rsp_valid !== 1'b0) obs_early_rsp = 1'b1;
            axi.rvalid = 1'b1; axi.rdata = beat_d[k]; axi.rresp = beat_resp[k];
            axi.rid = beat_id[k]; axi.rlast = (k == n - 1);
            @(negedge clk);
            axi.rvalid = 1'b0; axi.rlast = 1'b0;
        end
        obs_rsp_lat = 0;
        while (!rsp_valid && obs_rsp_lat < 20) begin
            @(negedge clk);
            obs_rsp_lat++;
        end
        if (!rsp_valid) obs_timeout++;
        obs_line = rsp_data;
        obs_err = rsp_err;
        obs_hold_ok = 1'b1;
        repeat (rsp_wait) begin
            @(negedge clk);
            if (rsp_data !== obs_line || rsp_err !== obs_err || req_ready !== 1'b0 ||
                axi.arvalid !== 1'b0 || rsp_valid !== 1'b1) obs_hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        obs_idle = req_ready && !rsp_valid;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        n_cmp++; if ({axi.arvalid, axi.rready, rsp_valid, rsp_err} !== 4'b0) begin n_bad++;
            $display("FAIL reset_ctrl got %b want 0000", {axi.arvalid, axi.rready, rsp_valid, rsp_err}); end
        n_cmp++; if ({axi.araddr, axi.arburst} !== 34'd0 || rsp_data !== 512'd0) begin n_bad++;
            $display("FAIL reset_data araddr %h arburst %0d want 0", axi.araddr, axi.arburst); end
        n_cmp++; if ({axi.arid, axi.arlen, axi.arsize} !== {4'd0, 4'd7, 3'd3}) begin n_bad++;
            $display("FAIL reset_const got id %0d len %0d size %0d want 0 7 3", axi.arid, axi.arlen, axi.arsize); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] a = 32'h1000;
        for (int k = 0; k < 16; k++) begin beat_d[k] = 64'(k); beat_resp[k] = 2'd0; beat_id[k] = 4'd0; end
        do_fill(a, 8, 1, 0);
        n_cmp++; if (obs_timeout !== 0) begin n_bad++; $display("FAIL basic_timeout got %0d want 0", obs_timeout); end
        n_cmp++; if (obs_req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_req_ready got %b want 1", obs_req_ready); end
        n_cmp++; if (obs_ar_lat !== 1) begin n_bad++; $display("FAIL basic_ar_latency got %0d want 1", obs_ar_lat); end
        n_cmp++; if (obs_araddr !== 32'h1000) begin n_bad++; $display("FAIL basic_araddr got %h want 00001000", obs_araddr); end
        n_cmp++; if ({obs_arlen, obs_arsize, obs_arid} !== {4'd7, 3'd3, 4'd0}) begin n_bad++;
            $display("FAIL basic_ar_fields got len %0d size %0d id %0d want 7 3 0", obs_arlen, obs_arsize, obs_arid); end
        n_cmp++; if (obs_arburst !== model_arburst()) begin n_bad++;
            $display("FAIL basic_arburst got %0d want %0d", obs_arburst, model_arburst()); end
        n_cmp++; if (obs_ar_stable !== 1'b1 || obs_rready_ok !== 1'b1 || obs_early_rsp !== 1'b0) begin n_bad++;
            $display("FAIL basic_handshake got stable %b rready %b early %b want 1 1 0", obs_ar_stable, obs_rready_ok, obs_early_rsp); end
        n_cmp++; if (obs_line !== model_line(a, 8)) begin n_bad++;
            $display("FAIL basic_line got %h want %h", obs_line, model_line(a, 8)); end
        n_cmp++; if (obs_err !== 1'b0 || obs_rsp_lat !== 0) begin n_bad++;
            $display("FAIL basic_err got err %b lat %0d want 0 0", obs_err, obs_rsp_lat); end
        n_cmp++; if (obs_idle !== 1'b1) begin n_bad++; $display("FAIL basic_idle got %b want 1", obs_idle); end
    endtask

    task automatic test_addr_map();
        logic [31:0] a = 32'h1028;
        gen_beats();
        do_fill(a, 8, 0, 0);
        n_cmp++; if (obs_araddr !== model_araddr(a)) begin n_bad++;
            $display("FAIL map_araddr got %h want %h", obs_araddr, model_araddr(a)); end
        n_cmp++; if (obs_arburst !== model_arburst()) begin n_bad++;
            $display("FAIL map_arburst got %0d want %0d", obs_arburst, model_arburst()); end
        n_cmp++; if (obs_line !== model_line(a, 8) || obs_err !== 1'b0) begin n_bad++;
            $display("FAIL map_line got %h err %b want %h err 0", obs_line, obs_err, model_line(a, 8)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a = $urandom;
            gen_beats();
            if ($urandom_range(0, 2) == 0) beat_resp[$urandom_range(0, 7)] = 2'($urandom_range(1, 3));
            do_fill(a, 8, $urandom_range(0, 3), $urandom_range(0, 3));
            n_cmp++; if (obs_timeout !== 0 || obs_ar_stable !== 1'b1 || obs_hold_ok !== 1'b1) begin n_bad++;
                $display("FAIL rand%0d_flow got timeout %0d stable %b hold %b want 0 1 1", i, obs_timeout, obs_ar_stable, obs_hold_ok); end
            n_cmp++; if (obs_araddr !== model_araddr(a)) begin n_bad++;
                $display("FAIL rand%0d_araddr got %h want %h", i, obs_araddr, model_araddr(a)); end
            n_cmp++; if (obs_line !== model_line(a, 8)) begin n_bad++;
                $display("FAIL rand%0d_line got %h want %h", i, obs_line, model_line(a, 8)); end
            n_cmp++; if (obs_err !== model_err(8)) begin n_bad++;
                $display("FAIL rand%0d_err got %b want %b", i, obs_err, model_err(8)); end
        end
    endtask

    task automatic test_error_sticky();
        logic [31:0] a = 32'h2040;
        gen_beats();
        beat_resp[3] = 2'd2;
        do_fill(a, 8, 1, 1);
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL sticky_err got %b want 1", obs_err); end
        n_cmp++; if (obs_line !== model_line(a, 8)) begin n_bad++;
            $display("FAIL sticky_line got %h want %h", obs_line, model_line(a, 8)); end
        gen_beats();
        do_fill(a, 8, 0, 0);
        n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL sticky_cleared got %b want 0", obs_err); end
        gen_beats();
        beat_id[6] = 4'd5;
        do_fill(32'h3018, 8, 0, 0);
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL bad_rid_err got %b want 1", obs_err); end
    endtask

    task automatic test_length();
        logic [31:0] a = 32'h4010;
        gen_beats();
        do_fill(a, 6, 0, 0);
        n_cmp++; if (obs_early_rsp !== 1'b0 || obs_rsp_lat !== 0 || obs_timeout !== 0) begin n_bad++;
            $display("FAIL short_timing got early %b lat %0d timeout %0d want 0 0 0", obs_early_rsp, obs_rsp_lat, obs_timeout); end
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL short_err got %b want 1", obs_err); end
        n_cmp++; if (((obs_line ^ model_line(a, 6)) & model_mask(a, 6)) !== 512'd0) begin n_bad++;
            $display("FAIL short_line got %h want %h", obs_line, model_line(a, 6)); end
        gen_beats();
        do_fill(a, 10, 0, 0);
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL long_err got %b want 1", obs_err); end
        n_cmp++; if (obs_line !== model_line(a, 10)) begin n_bad++;
            $display("FAIL long_line got %h want %h", obs_line, model_line(a, 10)); end
    endtask

    task automatic test_reset_mid();
        gen_beats();
        @(negedge clk);
        req_addr = 32'h5008; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            axi.rvalid = 1'b1; axi.rdata = beat_d[k]; axi.rresp = 2'd0; axi.rid = 4'd0; axi.rlast = 1'b0;
            if (k < 4) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({req_ready, axi.arvalid, axi.rready, rsp_valid, rsp_err} !== 5'b0) begin n_bad++;
            $display("FAIL midreset_ctrl got %b want 00000", {req_ready, axi.arvalid, axi.rready, rsp_valid, rsp_err}); end
        n_cmp++; if (rsp_data !== 512'd0 || axi.araddr !== 32'd0 || axi.arburst !== 2'd0) begin n_bad++;
            $display("FAIL midreset_data got araddr %h burst %0d line %h want 0", axi.araddr, axi.arburst, rsp_data); end
        @(negedge clk);
        axi.rvalid = 1'b0;
        rst_n = 1'b1;
        gen_beats();
        do_fill(32'h6030, 8, 2, 0);
        n_cmp++; if (obs_line !== model_line(32'h6030, 8) || obs_err !== 1'b0 || obs_timeout !== 0) begin n_bad++;
            $display("FAIL midreset_refill got %h err %b want %h err 0", obs_line, obs_err, model_line(32'h6030, 8)); end
    endtask

    task automatic test_rsp_hold();
        gen_beats();
        beat_resp[0] = 2'd3;
        do_fill(32'h7000, 8, 0, 10);
        n_cmp++; if (obs_hold_ok !== 1'b1) begin n_bad++; $display("FAIL hold_stable got %b want 1", obs_hold_ok); end
        n_cmp++; if (obs_err !== 1'b1 || obs_idle !== 1'b1) begin n_bad++;
            $display("FAIL hold_err_idle got err %b idle %b want 1 1", obs_err, obs_idle); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 63));
            gen_beats();
            do_fill(a, 8, 0, 0);
            n_cmp++; if (obs_line !== model_line(a, 8) || obs_err !== 1'b0 || obs_ar_lat !== 1) begin n_bad++;
                $display("FAIL b2b%0d got %h err %b lat %0d want %h err 0 lat 1", i, obs_line, obs_err, obs_ar_lat, model_line(a, 8)); end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        test_reset();
        test_basic();
        test_addr_map();
        test_random();
        test_error_sticky();
        test_length();
        test_reset_mid();
        test_rsp_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
